// File: rtl/average_nvals_acc.sv
// Block averager: accumulates N = 2^LOG2_N unsigned samples, then spends one
// cycle dividing by N (shift, optional round-half-up) and pulses avg_valid.
module average_nvals_acc #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 2,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              sample_ready,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid,
  output logic              busy,
  output logic [LOG2_N:0]   count
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int N     = 1 << LOG2_N;
  // Rounding bias is half an LSB of the quotient; zero when truncating or N = 1.
  localparam int BIAS  = (ROUND != 0) ? ((1 << LOG2_N) >> 1) : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DIV
  } state_t;

  state_t              state, state_nx;
  logic [ACC_W-1:0]    acc, acc_nx;
  logic [CNT_W-1:0]    count_nx;
  logic [DATA_W-1:0]   avg_nx;
  logic                avg_valid_nx;
  logic                accept;
  logic                last_accept;
  logic [ACC_W:0]      quot;
  logic [DATA_W-1:0]   div_result;

  assign sample_ready = (state == S_ACC);
  assign busy         = ((state == S_ACC) && (count != '0)) || (state == S_DIV);
  assign accept       = sample_valid && sample_ready;
  assign last_accept  = accept && (count == CNT_W'(N - 1));

  // One spare bit absorbs the rounding bias; saturate anything above full scale.
  assign quot       = ({1'b0, acc} + (ACC_W + 1)'(BIAS)) >> LOG2_N;
  assign div_result = (|quot[ACC_W:DATA_W]) ? '1 : quot[DATA_W-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nx     = state;
    acc_nx       = acc;
    count_nx     = count;
    avg_nx       = avg;
    avg_valid_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_nx = S_ACC;
      end
      S_ACC: begin
        if (!enable) begin
          // Dropping enable abandons the partial block, including a same-edge accept.
          state_nx = S_IDLE;
          acc_nx   = '0;
          count_nx = '0;
        end else if (accept) begin
          acc_nx = acc + ACC_W'(sample);
          if (last_accept) begin
            count_nx = '0;
            state_nx = S_DIV;
          end else begin
            count_nx = count + CNT_W'(1);
          end
        end
      end
      S_DIV: begin
        avg_nx       = div_result;
        avg_valid_nx = 1'b1;
        acc_nx       = '0;
        count_nx     = '0;
        state_nx     = enable ? S_ACC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous); state uses non-blocking
    // assignments so every register updates from pre-edge values.
    if (!reset_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      count     <= count_nx;
      avg       <= avg_nx;
      avg_valid <= avg_valid_nx;
    end
  end

endmodule

// File: doc/average_nvals_acc.md
AVERAGE_NVALS_ACC -- requirements
Module: average_nvals_acc

Interface
REQ-001 Parameter DATA_W, default 16, sample and average width in bits (legal range 4..32).
REQ-002 Parameter LOG2_N, default 2, log2 of samples per average; N = 2^LOG2_N (legal range 0..8).
REQ-003 Parameter ROUND, default 0, 0 = truncate, 1 = round half up.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  run control; low forces IDLE.
REQ-007 sample_valid  input  1  sample present this cycle.
REQ-008 sample  input  DATA_W  unsigned sample value.
REQ-009 sample_ready  output  1  block accepts a sample this cycle; accept = sample_valid && sample_ready.
REQ-010 avg  output  DATA_W  registered result of the last completed average.
REQ-011 avg_valid  output  1  single-cycle pulse marking a new avg value.
REQ-012 busy  output  1  high in ACC with count > 0, and in DIV.
REQ-013 count  output  LOG2_N+1  samples accepted in the current block (0..N-1).

Function
REQ-014 State machine SHALL have three states: IDLE, ACC, DIV.
REQ-015 IDLE: sample_ready = 0; the block moves to ACC on the edge where enable = 1.
REQ-016 ACC: sample_ready = 1; each accept adds sample to the accumulator and increments count.
REQ-017 Accumulator width SHALL be DATA_W+LOG2_N bits, so N full-scale samples never overflow.
REQ-018 ACC to DIV SHALL occur on the edge that accepts the Nth sample; that edge also adds the Nth sample.
REQ-019 DIV SHALL last exactly one cycle with sample_ready = 0; a sample_valid during DIV is not accepted and not counted.
REQ-020 On the DIV exit edge, avg SHALL load (acc >> LOG2_N) when ROUND = 0.
REQ-021 On the DIV exit edge, avg SHALL load ((acc + 2^(LOG2_N-1)) >> LOG2_N) when ROUND = 1 and LOG2_N > 0, saturated to 2^DATA_W-1.
REQ-022 On the same DIV exit edge, the accumulator and count SHALL clear and the state SHALL return to ACC (IDLE if enable = 0).
REQ-023 avg_valid SHALL be high for exactly the one cycle following DIV; latency is 2 clocks from the Nth-accept edge to the avg_valid-high cycle.
REQ-024 In the cycle after DIV, sample_ready SHALL be 1, so back-to-back blocks lose no samples apart from the single DIV cycle.
REQ-025 LOG2_N = 0: every accept SHALL go to DIV and avg SHALL equal the sample.
REQ-026 enable low in ACC SHALL move the state to IDLE on the next edge and clear the accumulator and count, with no avg_valid and avg retained; a sample accepted on that same edge is discarded.
REQ-027 enable low during DIV SHALL still complete the division; the next state is IDLE.
REQ-028 avg SHALL change only on a DIV exit edge.

Reset
REQ-029 When reset_n = 0 at an edge: state = IDLE, accumulator = 0, count = 0, avg = 0, avg_valid = 0. Outputs derived from state follow: sample_ready = 0, busy = 0.
REQ-030 Reset SHALL take priority over every other input, including during DIV; a partial block is discarded without producing avg_valid.

Verification
REQ-031 Defaults, enable = 1, sample_valid held high, samples 10, 20, 30, 40 -> avg = 25 and avg_valid high for 1 cycle, 2 clocks after the 4th accept; count sequence 1, 2, 3, 0.
REQ-032 Rounding, samples 1, 2, 2, 2 (sum 7) -> avg = 1 with ROUND = 0 and avg = 2 with ROUND = 1.
REQ-033 Full-scale, 4 x 0xFFFF -> avg = 0xFFFF, for both ROUND = 0 and ROUND = 1.
REQ-034 Continuous sample_valid over two blocks, value 0x0100 in the DIV cycle -> that value is not counted; the second block averages only the 4 accepted samples.
REQ-035 enable dropped after 2 accepts -> IDLE, count = 0, no avg_valid, avg unchanged; after re-enable, 4 new samples 8, 8, 8, 8 -> avg = 8.
REQ-036 reset_n pulsed low during DIV -> no avg_valid, avg = 0, sample_ready = 0 the next cycle; LOG2_N = 0 build -> avg equals each sample with avg_valid 2 clocks later.
